// File: rtl/fht_addr_seq.sv
// Address/control sequencer for an in-place radix-2 FHT: generates butterfly read/write
// pairs, twiddle addresses and ping-pong bank write enables for LOG_N stages.
`timescale 1ns/1ps
module fht_addr_seq #(
  parameter int LOG_N = 10,
  parameter int LAT   = 4
) (
  input  logic                       iCLK,
  input  logic                       iRESET,
  input  logic                       iSTART,
  input  logic                       iHOLD,
  output logic [LOG_N-1:0]           oADDR_RD_0,
  output logic [LOG_N-1:0]           oADDR_RD_1,
  output logic [LOG_N-1:0]           oADDR_WR_0,
  output logic [LOG_N-1:0]           oADDR_WR_1,
  output logic [LOG_N-2:0]           oADDR_COEF,
  output logic                       oRD_EN,
  output logic                       oWE_A,
  output logic                       oWE_B,
  output logic [$clog2(LOG_N)-1:0]   oSTAGE,
  output logic                       oST_ZERO,
  output logic                       oST_LAST,
  output logic                       oRES_BANK,
  output logic                       oDONE,
  output logic                       oRDY
);

  localparam int SW = $clog2(LOG_N);
  localparam int KW = LOG_N - 1;
  localparam logic [KW-1:0] K_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG_N - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  typedef struct packed {
    logic             v;
    logic             bank;
    logic [LOG_N-1:0] a;
    logic [LOG_N-1:0] b;
  } ent_t;

  state_t            state;
  logic [KW-1:0]     k;
  logic [SW-1:0]     stage;
  logic [LOG_N-1:0]  rd_a, rd_b;
  logic [KW-1:0]     rd_coef;
  logic              rd_vld, wr_bank, act_q, done_q, rdy_q, st_zero_q, st_last_q;
  ent_t [LAT-1:0]    pipe;
  ent_t [LAT:0]      chain;
  logic              issue, drained;
  logic [KW-1:0]     iss_k;
  logic [SW-1:0]     iss_s;

  // Insert a zero at bit s of k: the low s bits stay, the rest move up one place.
  function automatic logic [LOG_N-1:0] addr_a(input logic [KW-1:0] kk, input logic [SW-1:0] s);
    logic [LOG_N-1:0] kx, lo;
    kx = {1'b0, kk};
    lo = (LOG_N'(1) << s) - LOG_N'(1);
    return ((kx & ~lo) << 1) | (kx & lo);
  endfunction

  function automatic logic [LOG_N-1:0] addr_b(input logic [KW-1:0] kk, input logic [SW-1:0] s);
    return addr_a(kk, s) | (LOG_N'(1) << s);
  endfunction

  function automatic logic [KW-1:0] addr_coef(input logic [KW-1:0] kk, input logic [SW-1:0] s);
    logic [KW-1:0] lo;
    lo = (KW'(1) << s) - KW'(1);
    return (kk & lo) << (S_LAST - s);
  endfunction

  // chain[0] is the read just issued, chain[i] the entry i active cycles older.
  assign chain = {pipe, ent_t'{rd_vld, wr_bank, rd_a, rd_b}};

  always_comb begin
    drained = 1'b1;
    for (int i = 0; i < LAT; i++)
      if (chain[i].v) drained = 1'b0;
  end

  always_comb begin
    issue = 1'b0;
    iss_k = '0;
    iss_s = stage;
    unique case (state)
      IDLE:  if (iSTART) begin
               issue = 1'b1;
               iss_s = '0;
             end
      READ:  begin
               issue = 1'b1;
               iss_k = k;
             end
      DRAIN: if (drained && stage != S_LAST) begin
               issue = 1'b1;
               iss_s = stage + 1'b1;
             end
      default: ;
    endcase
  end

  // Stage: issue -- FSM, butterfly counter and registered read-side outputs
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state     <= IDLE;
      k         <= '0;
      stage     <= '0;
      rd_a      <= '0;
      rd_b      <= '0;
      rd_coef   <= '0;
      rd_vld    <= 1'b0;
      wr_bank   <= 1'b0;
      act_q     <= 1'b0;
      done_q    <= 1'b0;
      rdy_q     <= 1'b1;
      st_zero_q <= 1'b0;
      st_last_q <= 1'b0;
    end else begin
      act_q  <= ~iHOLD;
      done_q <= 1'b0;
      if (!iHOLD) begin
        rd_vld <= issue;
        if (issue) begin
          rd_a      <= addr_a(iss_k, iss_s);
          rd_b      <= addr_b(iss_k, iss_s);
          rd_coef   <= addr_coef(iss_k, iss_s);
          wr_bank   <= ~iss_s[0];
          k         <= iss_k + 1'b1;
          stage     <= iss_s;
          st_zero_q <= (iss_s == '0);
          st_last_q <= (iss_s == S_LAST);
          rdy_q     <= 1'b0;
        end
        unique case (state)
          IDLE:  if (iSTART) state <= READ;
          READ:  if (k == K_LAST) state <= DRAIN;
          DRAIN: if (drained) begin
                   if (stage == S_LAST) begin
                     state     <= IDLE;
                     done_q    <= 1'b1;
                     rdy_q     <= 1'b1;
                     stage     <= '0;
                     st_zero_q <= 1'b0;
                     st_last_q <= 1'b0;
                   end else begin
                     state <= READ;
                   end
                 end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Stage: write pipeline -- shifts only on active cycles so holds stretch it
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET)     pipe <= '0;
    else if (!iHOLD) pipe <= chain[LAT-1:0];
  end

  // Enables are qualified by the registered active flag so a held cycle reads as idle.
  assign oADDR_RD_0 = rd_a;
  assign oADDR_RD_1 = rd_b;
  assign oADDR_COEF = rd_coef;
  assign oADDR_WR_0 = chain[LAT].a;
  assign oADDR_WR_1 = chain[LAT].b;
  assign oRD_EN     = act_q & rd_vld;
  assign oWE_A      = act_q & chain[LAT].v & ~chain[LAT].bank;
  assign oWE_B      = act_q & chain[LAT].v &  chain[LAT].bank;
  assign oSTAGE     = stage;
  assign oST_ZERO   = st_zero_q;
  assign oST_LAST   = st_last_q;
  assign oRES_BANK  = (LOG_N % 2) == 1;
  assign oDONE      = done_q;
  assign oRDY       = rdy_q;

endmodule

// File: tb/tb_fht_addr_seq.sv
// Bench for fht_addr_seq: three instances checked cycle by cycle against an active-cycle
// schedule model plus directed count and address-table checks.
`timescale 1ns/1ps
module tb_fht_addr_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic hold = 1'b0;
  int   sel = 0;

  always #5 clk = ~clk;

  logic st3, hd3, st4, hd4, st10, hd10;
  assign st3  = start & (sel == 0);
  assign hd3  = hold  & (sel == 0);
  assign st4  = start & (sel == 1);
  assign hd4  = hold  & (sel == 1);
  assign st10 = start & (sel == 2);
  assign hd10 = hold  & (sel == 2);

  logic [2:0] r3_ra0, r3_ra1, r3_wa0, r3_wa1;
  logic [1:0] r3_co, r3_stg;
  logic       r3_rd, r3_wea, r3_web, r3_sz, r3_sl, r3_rb, r3_dn, r3_rdy;
  logic [3:0] r4_ra0, r4_ra1, r4_wa0, r4_wa1;
  logic [2:0] r4_co;
  logic [1:0] r4_stg;
  logic       r4_rd, r4_wea, r4_web, r4_sz, r4_sl, r4_rb, r4_dn, r4_rdy;
  logic [9:0] r10_ra0, r10_ra1, r10_wa0, r10_wa1;
  logic [8:0] r10_co;
  logic [3:0] r10_stg;
  logic       r10_rd, r10_wea, r10_web, r10_sz, r10_sl, r10_rb, r10_dn, r10_rdy;

  fht_addr_seq #(.LOG_N(3), .LAT(2)) u_d3 (
    .iCLK(clk), .iRESET(rst_n), .iSTART(st3), .iHOLD(hd3),
    .oADDR_RD_0(r3_ra0), .oADDR_RD_1(r3_ra1), .oADDR_WR_0(r3_wa0), .oADDR_WR_1(r3_wa1),
    .oADDR_COEF(r3_co), .oRD_EN(r3_rd), .oWE_A(r3_wea), .oWE_B(r3_web), .oSTAGE(r3_stg),
    .oST_ZERO(r3_sz), .oST_LAST(r3_sl), .oRES_BANK(r3_rb), .oDONE(r3_dn), .oRDY(r3_rdy));

  fht_addr_seq #(.LOG_N(4), .LAT(3)) u_d4 (
    .iCLK(clk), .iRESET(rst_n), .iSTART(st4), .iHOLD(hd4),
    .oADDR_RD_0(r4_ra0), .oADDR_RD_1(r4_ra1), .oADDR_WR_0(r4_wa0), .oADDR_WR_1(r4_wa1),
    .oADDR_COEF(r4_co), .oRD_EN(r4_rd), .oWE_A(r4_wea), .oWE_B(r4_web), .oSTAGE(r4_stg),
    .oST_ZERO(r4_sz), .oST_LAST(r4_sl), .oRES_BANK(r4_rb), .oDONE(r4_dn), .oRDY(r4_rdy));

  fht_addr_seq #(.LOG_N(10), .LAT(4)) u_d10 (
    .iCLK(clk), .iRESET(rst_n), .iSTART(st10), .iHOLD(hd10),
    .oADDR_RD_0(r10_ra0), .oADDR_RD_1(r10_ra1), .oADDR_WR_0(r10_wa0), .oADDR_WR_1(r10_wa1),
    .oADDR_COEF(r10_co), .oRD_EN(r10_rd), .oWE_A(r10_wea), .oWE_B(r10_web), .oSTAGE(r10_stg),
    .oST_ZERO(r10_sz), .oST_LAST(r10_sl), .oRES_BANK(r10_rb), .oDONE(r10_dn), .oRDY(r10_rdy));

  logic [31:0] o_ra0, o_ra1, o_wa0, o_wa1, o_co, o_stg;
  logic        o_rd, o_wea, o_web, o_sz, o_sl, o_rb, o_dn, o_rdy;

  always_comb begin
    case (sel)
      0: begin
        o_ra0 = 32'(r3_ra0); o_ra1 = 32'(r3_ra1); o_wa0 = 32'(r3_wa0); o_wa1 = 32'(r3_wa1);
        o_co = 32'(r3_co); o_stg = 32'(r3_stg); o_rd = r3_rd; o_wea = r3_wea; o_web = r3_web;
        o_sz = r3_sz; o_sl = r3_sl; o_rb = r3_rb; o_dn = r3_dn; o_rdy = r3_rdy;
      end
      1: begin
        o_ra0 = 32'(r4_ra0); o_ra1 = 32'(r4_ra1); o_wa0 = 32'(r4_wa0); o_wa1 = 32'(r4_wa1);
        o_co = 32'(r4_co); o_stg = 32'(r4_stg); o_rd = r4_rd; o_wea = r4_wea; o_web = r4_web;
        o_sz = r4_sz; o_sl = r4_sl; o_rb = r4_rb; o_dn = r4_dn; o_rdy = r4_rdy;
      end
      default: begin
        o_ra0 = 32'(r10_ra0); o_ra1 = 32'(r10_ra1); o_wa0 = 32'(r10_wa0); o_wa1 = 32'(r10_wa1);
        o_co = 32'(r10_co); o_stg = 32'(r10_stg); o_rd = r10_rd; o_wea = r10_wea; o_web = r10_web;
        o_sz = r10_sz; o_sl = r10_sl; o_rb = r10_rb; o_dn = r10_dn; o_rdy = r10_rdy;
      end
    endcase
  end

  int npass = 0;
  int ntot  = 0;

  // Schedule model: position j counts active cycles since the first read.
  int logn, lat, H, P, T;
  bit running = 1'b0;
  int j = 0;
  int e_ra0, e_ra1, e_co, e_wa0, e_wa1;
  int busy_c, rd_c, wr_c, both_c, done_c;
  int rd_log[$];

  function automatic int ref_a(int k, int s);
    return ((k >> s) << (s + 1)) | (k & ((1 << s) - 1));
  endfunction

  function automatic int ref_coef(int k, int s, int ln);
    return (k & ((1 << s) - 1)) << (ln - 1 - s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic clear_counts();
    busy_c = 0; rd_c = 0; wr_c = 0; both_c = 0; done_c = 0;
    rd_log.delete();
  endtask

  task automatic evaluate(input bit actq, input bit in_reset);
    bit busy, x_rd, x_we;
    int s, o;
    busy = running && (j < T);
    s = 0; o = 0; x_rd = 1'b0; x_we = 1'b0;
    if (busy) begin
      s = j / P;
      o = j % P;
      x_rd = actq && (o < H);
      x_we = actq && (o >= lat) && (o < lat + H);
      if (x_rd) begin
        e_ra0 = ref_a(o, s);
        e_ra1 = e_ra0 + (1 << s);
        e_co  = ref_coef(o, s, logn);
      end
      if (x_we) begin
        e_wa0 = ref_a(o - lat, s);
        e_wa1 = e_wa0 + (1 << s);
      end
    end
    chk("rdy", o_rdy, !busy);
    chk("done", o_dn, running && (j == T));
    chk("rd_en", o_rd, x_rd);
    chk("we_a", o_wea, x_we && (s % 2 == 1));
    chk("we_b", o_web, x_we && (s % 2 == 0));
    chk("rd_addr0", o_ra0, e_ra0);
    chk("rd_addr1", o_ra1, e_ra1);
    chk("coef", o_co, e_co);
    chk("wr_addr0", o_wa0, e_wa0);
    chk("wr_addr1", o_wa1, e_wa1);
    chk("st_zero", o_sz, busy && (s == 0));
    chk("st_last", o_sl, busy && (s == logn - 1));
    chk("res_bank", o_rb, logn % 2);
    if (busy || in_reset) chk("stage", o_stg, s);
    if (!o_rdy) busy_c++;
    if (o_rd) begin
      rd_c++;
      rd_log.push_back(int'(o_ra0) * 100 + int'(o_ra1) * 10 + int'(o_co));
    end
    if (o_wea || o_web) wr_c++;
    if (o_wea && o_web) both_c++;
    if (o_dn) done_c++;
  endtask

  task automatic cyc(input bit st, input bit hd);
    start = st;
    hold  = hd;
    @(posedge clk);
    if (!running || j == T) begin
      if (!hd && st) begin
        running = 1'b1;
        j = 0;
      end else begin
        running = 1'b0;
      end
    end else if (!hd) begin
      j++;
    end
    @(negedge clk);
    evaluate(!hd, 1'b0);
  endtask

  task automatic do_reset(input int s);
    @(negedge clk);
    sel = s;
    logn = (s == 0) ? 3 : (s == 1) ? 4 : 10;
    lat  = (s == 0) ? 2 : (s == 1) ? 3 : 4;
    H = 1 << (logn - 1);
    P = H + lat;
    T = logn * P;
    start = 1'b0;
    hold  = 1'b0;
    rst_n = 1'b0;
    #1;
    running = 1'b0;
    e_ra0 = 0; e_ra1 = 0; e_co = 0; e_wa0 = 0; e_wa1 = 0;
    evaluate(1'b0, 1'b1);
    @(negedge clk);
    evaluate(1'b0, 1'b1);
    rst_n = 1'b1;
  endtask

  task automatic run_to_idle(input int budget, input bit rnd);
    int n;
    n = 0;
    while (running && j < T && n < budget) begin
      if (rnd) cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      else     cyc(1'b0, 1'b0);
      n++;
    end
    chk("finish_in_budget", n < budget, 1);
    cyc(1'b0, 1'b0);
  endtask

  int tab3[12] = '{10, 230, 450, 670, 20, 132, 460, 572, 40, 151, 262, 373};

  initial begin
    // Plain single transform, LOG_N=3 LAT=2, against the literal address table
    do_reset(0);
    clear_counts();
    cyc(1'b1, 1'b0);
    run_to_idle(100, 1'b0);
    chk("busy_cycles_3", busy_c, 18);
    chk("done_pulses_3", done_c, 1);
    chk("read_strobes_3", rd_c, 12);
    chk("write_strobes_3", wr_c, 12);
    chk("read_log_len", rd_log.size(), 12);
    for (int i = 0; i < 12 && i < rd_log.size(); i++) chk("read_table", rd_log[i], tab3[i]);

    // Three hold cycles at the stage 0 drain boundary
    clear_counts();
    cyc(1'b1, 1'b0);
    while (running && j < H) cyc(1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b1);
    run_to_idle(100, 1'b0);
    chk("busy_cycles_hold", busy_c, 21);
    chk("done_pulses_hold", done_c, 1);

    // Start pulsed during stage 1 is ignored
    clear_counts();
    cyc(1'b1, 1'b0);
    while (running && j < P + 1) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    run_to_idle(100, 1'b0);
    chk("busy_cycles_restart", busy_c, 18);
    chk("done_pulses_restart", done_c, 1);

    // Start while held in IDLE is ignored
    clear_counts();
    repeat (3) cyc(1'b1, 1'b1);
    chk("held_start_busy", busy_c, 0);

    // Back-to-back with start held high
    clear_counts();
    repeat (2 * (T + 1)) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("b2b_done_pulses", done_c, 2);
    chk("b2b_busy_cycles", busy_c, 2 * T);

    // Randomised holds and stray starts
    for (int t = 0; t < 3; t++) begin
      cyc(1'b1, 1'b0);
      run_to_idle(400, 1'b1);
    end

    // LOG_N=4: reset in the middle of stage 2, then a clean run
    do_reset(1);
    cyc(1'b1, 1'b0);
    while (running && j < 2 * P + 2) cyc(1'b0, 1'b0);
    do_reset(1);
    clear_counts();
    repeat (4) cyc(1'b0, 1'b0);
    chk("no_we_after_reset", wr_c, 0);
    cyc(1'b1, 1'b0);
    run_to_idle(200, 1'b0);
    chk("busy_cycles_4", busy_c, T);
    chk("write_strobes_4", wr_c, 4 * 8);
    cyc(1'b1, 1'b0);
    run_to_idle(400, 1'b1);

    // LOG_N=10 LAT=4 full length
    do_reset(2);
    clear_counts();
    cyc(1'b1, 1'b0);
    run_to_idle(6000, 1'b0);
    chk("busy_cycles_10", busy_c, 5160);
    chk("read_strobes_10", rd_c, 5120);
    chk("write_strobes_10", wr_c, 5120);
    chk("both_we_10", both_c, 0);
    chk("done_pulses_10", done_c, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
